// File: rtl/pe_accum_seq.sv
// PE job sequencer: issues beats, tags one flush per job; result captured LATENCY+1 cycles after the tag.
// Command backpressure via 2 result credits; results leave through a valid/ready 2-entry FIFO.
module pe_accum_seq #(
  parameter int LATENCY      = 3,
  parameter int CNT_W        = 16,
  parameter int RESULT_WIDTH = 32
) (
  input  logic                           clock,
  input  logic                           resetn,
  input  logic                           i_cmd_valid,
  output logic                           o_cmd_ready,
  input  logic        [CNT_W-1:0]        i_cmd_beats,
  input  logic                           i_operand_avail,
  output logic                           o_pe_valid,
  output logic                           o_pe_flush,
  input  logic signed [RESULT_WIDTH-1:0] i_pe_result,
  output logic                           o_res_valid,
  input  logic                           i_res_ready,
  output logic        [RESULT_WIDTH-1:0] o_res_data,
  output logic                           o_busy
);

  localparam logic [1:0] MAX_CREDITS = 2'd2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FLUSH0 = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [1:0]         credits_q, credits_d;
  logic               en_q;
  logic [LATENCY:0]   tag_pipe_q, tag_pipe_d;

  logic [RESULT_WIDTH-1:0] mem_q [2];
  logic                    wr_ptr_q, wr_ptr_d;
  logic                    rd_ptr_q, rd_ptr_d;
  logic [1:0]              fcnt_q, fcnt_d;

  logic flush_tag;
  logic cmd_acc;
  logic res_pop;
  logic capture;

  // en_q keeps ready low until the first edge after reset release
  assign o_cmd_ready = en_q && (state_q == IDLE) && (credits_q != 2'd0);
  assign cmd_acc     = i_cmd_valid && o_cmd_ready;
  assign res_pop     = o_res_valid && i_res_ready;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    o_pe_valid = 1'b0;
    flush_tag  = 1'b0;
    case (state_q)
      IDLE: begin
        if (cmd_acc) begin
          cnt_d = i_cmd_beats;
          if (i_cmd_beats != '0) begin
            state_d = RUN;
          end else begin
            state_d = FLUSH0;
          end
        end
      end
      RUN: begin
        if (i_operand_avail) begin
          o_pe_valid = 1'b1;
          cnt_d      = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            flush_tag = 1'b1;
            state_d   = IDLE;
          end
        end
      end
      FLUSH0: begin
        flush_tag = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // A credit is held from accept until its result is popped
  always_comb begin
    credits_d = credits_q;
    case ({cmd_acc, res_pop})
      2'b10:   credits_d = credits_q - 2'd1;
      2'b01:   credits_d = (credits_q != MAX_CREDITS) ? credits_q + 2'd1 : credits_q;
      default: credits_d = credits_q;
    endcase
  end

  // Bit LATENCY-1 is the flush strobe; bit LATENCY is the capture slot one cycle later
  assign tag_pipe_d = {tag_pipe_q[LATENCY-1:0], flush_tag};
  assign o_pe_flush = tag_pipe_q[LATENCY-1];
  assign capture    = tag_pipe_q[LATENCY];

  always_comb begin
    wr_ptr_d = capture ? ~wr_ptr_q : wr_ptr_q;
    rd_ptr_d = res_pop ? ~rd_ptr_q : rd_ptr_q;
    fcnt_d   = fcnt_q;
    case ({capture, res_pop})
      2'b10:   fcnt_d = fcnt_q + 2'd1;
      2'b01:   fcnt_d = fcnt_q - 2'd1;
      default: fcnt_d = fcnt_q;
    endcase
  end

  assign o_res_valid = (fcnt_q != 2'd0);
  assign o_res_data  = mem_q[rd_ptr_q];
  assign o_busy      = (state_q != IDLE) || (|tag_pipe_q) || o_res_valid;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      credits_q  <= MAX_CREDITS;
      en_q       <= 1'b0;
      tag_pipe_q <= '0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      fcnt_q     <= 2'd0;
      mem_q[0]   <= '0;
      mem_q[1]   <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      credits_q  <= credits_d;
      en_q       <= 1'b1;
      tag_pipe_q <= tag_pipe_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      fcnt_q     <= fcnt_d;
      // Credit reservation guarantees a free slot, so the write is unconditional
      if (capture) begin
        mem_q[wr_ptr_q] <= i_pe_result;
      end
    end
  end

endmodule

// File: tb/tb_pe_accum_seq.sv
// Bench for pe_accum_seq: directed job scenarios plus random jobs, checked
// cycle by cycle against a job-level timing model and a result scoreboard.
module tb_pe_accum_seq;
  localparam int L  = 3;
  localparam int CW = 16;
  localparam int RW = 32;
  localparam int NC = 4000;

  logic                 clock = 1'b0;
  logic                 resetn;
  logic                 i_cmd_valid;
  logic                 o_cmd_ready;
  logic [CW-1:0]        i_cmd_beats;
  logic                 i_operand_avail;
  logic                 o_pe_valid;
  logic                 o_pe_flush;
  logic signed [RW-1:0] i_pe_result;
  logic                 o_res_valid;
  logic                 i_res_ready;
  logic [RW-1:0]        o_res_data;
  logic                 o_busy;

  pe_accum_seq #(.LATENCY(L), .CNT_W(CW), .RESULT_WIDTH(RW)) dut (
    .clock          (clock),
    .resetn         (resetn),
    .i_cmd_valid    (i_cmd_valid),
    .o_cmd_ready    (o_cmd_ready),
    .i_cmd_beats    (i_cmd_beats),
    .i_operand_avail(i_operand_avail),
    .o_pe_valid     (o_pe_valid),
    .o_pe_flush     (o_pe_flush),
    .i_pe_result    (i_pe_result),
    .o_res_valid    (o_res_valid),
    .i_res_ready    (i_res_ready),
    .o_res_data     (o_res_data),
    .o_busy         (o_busy)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    logic [RW-1:0] dat;
    int            vcyc;
  } exp_t;

  exp_t          exp_q[$];
  bit            avail_pat[NC];
  logic [RW-1:0] pe_vals[NC];
  bit            exp_pv[NC];
  bit            exp_fl[NC];
  bit            exp_busy[NC];

  int acc_cnt, pop_cnt, last_a, last_t, en_cyc;
  bit has_job;
  int n_checks, n_err;
  int rdy_mode;
  bit acc_seen, got_acc;
  int acc_cyc;
  bit e_rdy, e_vld, e_idle;
  int a, a1, a2, s;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s (cycle %0d): actual=%0h required=%0h", nm, cyc, act, req);
    end
  endtask

  // Job-level model: the last beat lands on the b-th available cycle after accept
  // (or the cycle after accept for b=0); flush L later, data sampled one cycle after.
  task automatic model_accept(input int ac, input int b);
    int t, left;
    t = ac + 1;
    left = b;
    if (b > 0) begin
      for (int c = ac + 1; c < NC; c++) begin
        if (avail_pat[c]) begin
          exp_pv[c] = 1'b1;
          left--;
          if (left == 0) begin
            t = c;
            break;
          end
        end
      end
    end
    for (int c = ac + 1; c <= t + L + 1 && c < NC; c++) exp_busy[c] = 1'b1;
    if (t + L + 1 < NC) begin
      exp_t e;
      exp_fl[t + L] = 1'b1;
      e.dat  = pe_vals[t + L + 1];
      e.vcyc = t + L + 2;
      exp_q.push_back(e);
    end
    acc_cnt++;
    has_job = 1'b1;
    last_a  = ac;
    last_t  = t;
  endtask

  task automatic model_reset();
    exp_q.delete();
    acc_cnt  = 0;
    pop_cnt  = 0;
    has_job  = 1'b0;
    acc_seen = 1'b0;
    en_cyc   = 2 * NC;
    for (int c = cyc; c < NC; c++) begin
      exp_pv[c]   = 1'b0;
      exp_fl[c]   = 1'b0;
      exp_busy[c] = 1'b0;
    end
  endtask

  task automatic tick();
    @(negedge clock);
    #1;
    if (resetn && i_cmd_valid && o_cmd_ready) begin
      model_accept(cyc, int'(i_cmd_beats));
      acc_seen = 1'b1;
      acc_cyc  = cyc;
    end
    @(posedge clock);
    #1;
    if (acc_seen) begin
      acc_seen    = 1'b0;
      got_acc     = 1'b1;
      i_cmd_valid = 1'b0;
      i_cmd_beats = CW'($urandom);
    end
    i_operand_avail = avail_pat[cyc];
    i_pe_result     = pe_vals[cyc];
    case (rdy_mode)
      1: i_res_ready = 1'b1;
      2: i_res_ready = 1'($urandom_range(0, 1));
      3: begin
        i_res_ready = 1'b1;
        rdy_mode    = 0;
      end
      default: i_res_ready = 1'b0;
    endcase
  endtask

  task automatic wait_acc(input int maxn);
    int n;
    n = 0;
    while (!got_acc && n < maxn) begin
      tick();
      n++;
    end
    if (!got_acc) begin
      n_checks++;
      n_err++;
      $display("FAIL accept_timeout: no accept after %0d cycles, required accept", n);
      i_cmd_valid = 1'b0;
    end
  endtask

  task automatic run_job(input int b);
    got_acc     = 1'b0;
    i_cmd_valid = 1'b1;
    i_cmd_beats = CW'(b);
    wait_acc(300);
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  initial begin
    resetn = 1'b0;
    i_cmd_valid = 1'b0;
    i_cmd_beats = '0;
    i_operand_avail = 1'b0;
    i_pe_result = '0;
    i_res_ready = 1'b0;
    rdy_mode = 0;
    n_checks = 0;
    n_err = 0;
    acc_cnt = 0;
    pop_cnt = 0;
    has_job = 1'b0;
    last_a = 0;
    last_t = 0;
    acc_seen = 1'b0;
    got_acc = 1'b0;
    acc_cyc = 0;
    en_cyc = 2 * NC;
    for (int c = 0; c < NC; c++) begin
      avail_pat[c] = 1'b1;
      pe_vals[c]   = $urandom;
      exp_pv[c]    = 1'b0;
      exp_fl[c]    = 1'b0;
      exp_busy[c]  = 1'b0;
    end

    fork
      forever begin
        @(negedge clock);
        if (cyc >= NC - 2) begin
          $display("FAIL watchdog: cycle %0d reached limit %0d", cyc, NC);
          $fatal(1, "cycle limit");
        end
        if (!resetn) begin
          check("rst_cmd_ready", o_cmd_ready, 0);
          check("rst_pe_valid", o_pe_valid, 0);
          check("rst_pe_flush", o_pe_flush, 0);
          check("rst_res_valid", o_res_valid, 0);
          check("rst_res_data", o_res_data, 0);
          check("rst_busy", o_busy, 0);
        end else begin
          e_idle = !(has_job && cyc > last_a && cyc <= last_t);
          e_rdy  = (cyc >= en_cyc) && e_idle && (acc_cnt - pop_cnt < 2);
          e_vld  = (exp_q.size() > 0) && (exp_q[0].vcyc <= cyc);
          check("cmd_ready", o_cmd_ready, e_rdy);
          check("pe_valid", o_pe_valid, exp_pv[cyc]);
          check("pe_flush", o_pe_flush, exp_fl[cyc]);
          check("res_valid", o_res_valid, e_vld);
          check("busy", o_busy, exp_busy[cyc] || e_vld);
          if (o_res_valid) begin
            if (exp_q.size() == 0) begin
              n_checks++;
              n_err++;
              $display("FAIL res_unexpected (cycle %0d): actual data=%0h, required no result", cyc, o_res_data);
            end else begin
              check("res_data", o_res_data, exp_q[0].dat);
              if (i_res_ready) begin
                void'(exp_q.pop_front());
                pop_cnt++;
              end
            end
          end
        end
      end
    join_none

    tick();
    tick();
    resetn = 1'b1;
    en_cyc = cyc + 1;
    tick();

    // four beats, avail always high
    rdy_mode = 1;
    run_job(4);
    a = acc_cyc;
    while (cyc < a + 7) tick();
    check("r42_flush_c7", o_pe_flush, 1);
    tick();
    check("r42_flush_c8", o_pe_flush, 0);
    check("r42_vld_c8", o_res_valid, 0);
    tick();
    check("r42_vld_c9", o_res_valid, 1);
    check("r42_data_c9", o_res_data, pe_vals[a + 8]);
    idle(10);

    // zero-beat job
    run_job(0);
    a = acc_cyc;
    while (cyc < a + 4) tick();
    check("r43_flush_c4", o_pe_flush, 1);
    tick();
    tick();
    check("r43_vld_c6", o_res_valid, 1);
    idle(10);

    // credit exhaustion with consumer stalled
    rdy_mode = 0;
    run_job(1);
    run_job(1);
    got_acc = 1'b0;
    i_cmd_valid = 1'b1;
    i_cmd_beats = CW'(1);
    repeat (12) tick();
    check("r44_third_blocked", got_acc, 0);
    rdy_mode = 3;
    wait_acc(20);
    rdy_mode = 1;
    idle(20);

    // operand gaps
    s = cyc;
    avail_pat[s + 1] = 1'b1;
    avail_pat[s + 2] = 1'b0;
    avail_pat[s + 3] = 1'b0;
    avail_pat[s + 4] = 1'b1;
    avail_pat[s + 5] = 1'b1;
    run_job(3);
    check("r45_acc_cycle", acc_cyc, s);
    while (cyc < s + 8) tick();
    check("r45_flush_c8", o_pe_flush, 1);
    idle(15);

    // reset mid-job
    run_job(5);
    a = acc_cyc;
    while (cyc < a + 2) tick();
    resetn = 1'b0;
    model_reset();
    #1;
    check("r46_async_pe_valid", o_pe_valid, 0);
    check("r46_async_busy", o_busy, 0);
    check("r46_async_cmd_ready", o_cmd_ready, 0);
    tick();
    tick();
    resetn = 1'b1;
    en_cyc = cyc + 1;
    idle(20);
    run_job(2);
    idle(20);

    // back-to-back jobs
    run_job(2);
    a1 = acc_cyc;
    run_job(2);
    a2 = acc_cyc;
    check("r47_second_accept", a2 - a1, 3);
    while (cyc < a1 + 5) tick();
    check("r47_flush_c5", o_pe_flush, 1);
    while (cyc < a1 + 8) tick();
    check("r47_flush_c8", o_pe_flush, 1);
    idle(20);

    // random jobs, random operand availability and consumer stalls
    for (int c = cyc + 1; c < NC; c++) avail_pat[c] = ($urandom_range(0, 3) != 0);
    rdy_mode = 2;
    repeat (30) begin
      repeat ($urandom_range(0, 3)) tick();
      run_job($urandom_range(0, 6));
    end
    rdy_mode = 1;
    idle(40);
    check("drain_empty", exp_q.size(), 0);
    check("drain_busy", o_busy, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
